// File: rtl/led_scan_ctrl.sv
// Multiplexed LED scan controller: per group, BLANK dead cycles then DWELL lit cycles, snapshot taken once per frame.
// Latency: all outputs registered, one cycle after the deciding edge; nRST blanks the outputs asynchronously.
// Backpressure: none; EN low forces IDLE at the next edge. LED_SCAN_DIM_EN adds the DUTY dimming input.
module led_scan_ctrl #(
    parameter int GROUPS = 4,
    parameter int WIDTH  = 8,
    parameter int DWELL  = 256,
    parameter int BLANK  = 4
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        EN,
`ifdef LED_SCAN_DIM_EN
    input  logic [3:0]                  DUTY,
`endif
    input  logic [GROUPS*WIDTH-1:0]     DATA,
    output logic [WIDTH-1:0]            LED_A,
    output logic [GROUPS-1:0]           LED_GND,
    output logic [$clog2(GROUPS)-1:0]   GROUP_IDX,
    output logic                        FRAME_DONE
);

    localparam int IW   = $clog2(GROUPS);
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(GROUPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [GROUPS*WIDTH-1:0]    snap_q, snap_d;
    logic [WIDTH-1:0]           led_a_q, led_a_d;
    logic [GROUPS-1:0]          led_gnd_q, led_gnd_d;
    logic                       fd_q, fd_d;
    logic                       lit;
`ifdef LED_SCAN_DIM_EN
    logic [CW+3:0]              cnt_ext;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            led_a_q   <= '0;
            led_gnd_q <= '1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            led_a_q   <= led_a_d;
            led_gnd_q <= led_gnd_d;
            fd_q      <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        fd_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (EN) begin
                    state_d = ST_BLANK;
                    snap_d  = DATA;
                end
            end
            ST_BLANK: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == BLANK_END) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ON: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == DWELL_END) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    // Frame wrap: fresh snapshot so a frame never mixes old and new DATA.
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        snap_d = DATA;
                        fd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from next state so the registered pins line up with the state.
    always_comb begin
        lit = (state_d == ST_ON);
`ifdef LED_SCAN_DIM_EN
        cnt_ext = {4'b0000, cnt_d};
        lit     = lit && (cnt_ext[3:0] < DUTY);
`endif
        led_a_d   = '0;
        led_gnd_d = '1;
        for (int g = 0; g < GROUPS; g++) begin
            if (lit && (idx_d == IW'(g))) begin
                led_a_d      = snap_q[g*WIDTH +: WIDTH];
                led_gnd_d[g] = 1'b0;
            end
        end
    end

    assign LED_A      = led_a_q;
    assign LED_GND    = led_gnd_q;
    assign GROUP_IDX  = idx_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with GROUPS=4, WIDTH=8, DWELL=8, BLANK=2.
module tb_led_scan_ctrl;

    logic        CLK;
    logic        nRST;
    logic        EN;
    logic [31:0] DATA;
    logic [7:0]  LED_A;
    logic [3:0]  LED_GND;
    logic [1:0]  GROUP_IDX;
    logic        FRAME_DONE;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    bit mon_en = 1'b0;

    led_scan_ctrl #(
        .GROUPS(4),
        .WIDTH (8),
        .DWELL (8),
        .BLANK (2)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .EN        (EN),
`ifdef LED_SCAN_DIM_EN
        .DUTY      (4'hF),
`endif
        .DATA      (DATA),
        .LED_A     (LED_A),
        .LED_GND   (LED_GND),
        .GROUP_IDX (GROUP_IDX),
        .FRAME_DONE(FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    // At most one sink low; anodes only driven while a sink is low.
    always @(negedge CLK) begin
        if (mon_en) begin
            n_chk++;
            assert ($countones(~LED_GND) <= 1 && (LED_A == 8'h00 || LED_GND != 4'hF)) n_pass++;
            else $error("FAIL sink_onehot: observed gnd=%b a=%h expected at most one low sink", LED_GND, LED_A);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] a, input logic [3:0] gnd,
                           input logic [1:0] idx, input logic fd);
        chk({tag, ".a"},   {24'h0, LED_A},      {24'h0, a});
        chk({tag, ".gnd"}, {28'h0, LED_GND},    {28'h0, gnd});
        chk({tag, ".idx"}, {30'h0, GROUP_IDX},  {30'h0, idx});
        chk({tag, ".fd"},  {31'h0, FRAME_DONE}, {31'h0, fd});
    endtask

    initial begin
        nRST = 1'b0;
        EN   = 1'b0;
        DATA = 32'h0;
        repeat (3) step();
        chk_out("reset", 8'h00, 4'hF, 2'd0, 1'b0);

        // EN high while held in reset must not start the scan
        EN   = 1'b1;
        DATA = 32'h44332211;
        step();
        chk_out("reset_en", 8'h00, 4'hF, 2'd0, 1'b0);

        nRST   = 1'b1;
        mon_en = 1'b1;
        step();
        chk_out("blank0_c0", 8'h00, 4'hF, 2'd0, 1'b0);
        step();
        chk_out("blank0_c1", 8'h00, 4'hF, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_out($sformatf("on0_c%0d", i), 8'h11, 4'b1110, 2'd0, 1'b0);
        end
        step();
        chk_out("blank1_c0", 8'h00, 4'hF, 2'd1, 1'b0);
        step();
        chk_out("blank1_c1", 8'h00, 4'hF, 2'd1, 1'b0);
        step();
        chk_out("on1_c0", 8'h22, 4'b1101, 2'd1, 1'b0);

        // New DATA during group 1 must not tear the current frame
        DATA = 32'hFFFFFFFF;
        repeat (10) step();
        chk_out("on2_c0", 8'h33, 4'b1011, 2'd2, 1'b0);
        repeat (10) step();
        chk_out("on3_c0", 8'h44, 4'b0111, 2'd3, 1'b0);
        repeat (7) step();
        chk_out("on3_c7", 8'h44, 4'b0111, 2'd3, 1'b0);
        step();
        chk_out("wrap1", 8'h00, 4'hF, 2'd0, 1'b1);
        step();
        chk_out("wrap1_p1", 8'h00, 4'hF, 2'd0, 1'b0);
        step();
        chk_out("f2_on0", 8'hFF, 4'b1110, 2'd0, 1'b0);

        cyc = 2;
        while (!FRAME_DONE && cyc < 60) begin
            step();
            cyc++;
            if (cyc == 22) chk_out("f2_on2", 8'hFF, 4'b1011, 2'd2, 1'b0);
        end
        chk("frame_period", cyc, 40);
        chk("wrap2_idx", {30'h0, GROUP_IDX}, 32'd0);
        step();
        chk("wrap2_width", {31'h0, FRAME_DONE}, 32'd0);

        // Drop EN in the fifth ON cycle of group 2
        repeat (21) step();
        chk_out("f3_on2_c0", 8'hFF, 4'b1011, 2'd2, 1'b0);
        repeat (4) step();
        chk_out("f3_on2_c4", 8'hFF, 4'b1011, 2'd2, 1'b0);
        EN = 1'b0;
        step();
        chk_out("en_drop", 8'h00, 4'hF, 2'd0, 1'b0);
        step();
        chk_out("idle_hold", 8'h00, 4'hF, 2'd0, 1'b0);

        DATA = 32'h88776655;
        EN   = 1'b1;
        step();
        chk_out("restart_b0", 8'h00, 4'hF, 2'd0, 1'b0);
        step();
        step();
        chk_out("restart_on0", 8'h55, 4'b1110, 2'd0, 1'b0);
        step();
        step();
        chk_out("restart_on2", 8'h55, 4'b1110, 2'd0, 1'b0);

        // Asynchronous reset between edges while lit
        #2;
        nRST = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 4'hF, 2'd0, 1'b0);
        #2;
        nRST = 1'b1;
        step();
        chk_out("post_rst_b0", 8'h00, 4'hF, 2'd0, 1'b0);
        step();
        step();
        chk_out("post_rst_on0", 8'h55, 4'b1110, 2'd0, 1'b0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter GROUPS, default 4: number of LED groups, i.e. LED_GND sink lines; range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: LEDs per group, i.e. LED_A anode lines.
REQ-003 SHALL have parameter DWELL, default 256: ON cycles per group; must be at least 1.
REQ-004 SHALL have parameter BLANK, default 4: dead cycles before each group; must be at least 1.
REQ-005 SHALL have port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port nRST, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port EN, input, 1: scan enable, level-sensitive.
REQ-008 SHALL have port DATA, input, GROUPS*WIDTH: LED states; group g occupies bits [g*WIDTH +: WIDTH].
REQ-009 SHALL have port LED_A, output, WIDTH: anode drive to the LED/DECAP_LED A pins of the active group.
REQ-010 SHALL have port LED_GND, output, GROUPS: per-group sink line; active-low, where 0 means the group is lit.
REQ-011 SHALL have port GROUP_IDX, output, clog2(GROUPS): index of the current group.
REQ-012 SHALL have port FRAME_DONE, output, 1: one-cycle pulse at each frame wrap.

Function
REQ-013 SHALL implement FSM states IDLE, BLANK and ON; all outputs SHALL be registered.
REQ-014 IDLE SHALL drive LED_A=0, LED_GND=all 1, GROUP_IDX=0 and FRAME_DONE=0.
REQ-015 In IDLE with EN=1 at an edge, the FSM SHALL move to BLANK with GROUP_IDX=0 and SHALL capture DATA into a frame snapshot register at that same edge.
REQ-016 BLANK SHALL last exactly BLANK cycles and SHALL drive LED_A=0 and LED_GND=all 1, then move to ON.
REQ-017 ON SHALL last exactly DWELL cycles and SHALL drive LED_A=snapshot[GROUP_IDX*WIDTH +: WIDTH], LED_GND[GROUP_IDX]=0 and all other LED_GND bits=1.
REQ-018 At most one LED_GND bit SHALL be 0 in any cycle; LED_A SHALL be non-zero only while one LED_GND bit is 0.
REQ-019 At the end of ON with GROUP_IDX<GROUPS-1, GROUP_IDX SHALL increment by 1 and the FSM SHALL enter BLANK.
REQ-020 At the end of ON with GROUP_IDX=GROUPS-1:
- GROUP_IDX SHALL wrap to 0;
- the FSM SHALL enter BLANK;
- the snapshot SHALL be recaptured from DATA;
- FRAME_DONE SHALL be 1 for exactly that first BLANK cycle.
REQ-021 DATA changes mid-frame SHALL NOT affect LED_A until the next frame snapshot (no tearing).
REQ-022 Frame period SHALL be GROUPS*(BLANK+DWELL) cycles.
REQ-023 EN=0 sampled in BLANK or ON SHALL force IDLE at that edge: outputs blank next cycle, GROUP_IDX=0, no FRAME_DONE.
REQ-024 EN re-asserted after IDLE SHALL always restart at group 0 with a fresh snapshot.
REQ-025 Dwell and blank counters SHALL be sized clog2(max(DWELL,BLANK)+1) and SHALL never overflow.

Reset
REQ-026 nRST=0 SHALL asynchronously force:
- state IDLE;
- LED_A=0;
- LED_GND=all 1;
- GROUP_IDX=0;
- FRAME_DONE=0;
- counters 0;
- snapshot 0.
REQ-027 Reset deassertion SHALL be released synchronously to CLK; the first possible BLANK entry SHALL occur on the first edge with nRST=1 and EN=1.
REQ-028 Reset asserted mid-ON SHALL extinguish all LEDs immediately, without waiting for a clock edge.

Configuration
REQ-029 With LED_SCAN_DIM_EN defined, the block SHALL add input DUTY[3:0]; in ON, LED_GND[GROUP_IDX]=0 and LED_A=slice only when (ON cycle count mod 16) < DUTY, otherwise outputs are blank as in BLANK.
REQ-030 With LED_SCAN_DIM_EN defined, DUTY=0 SHALL keep all LEDs dark while timing, GROUP_IDX and FRAME_DONE remain unchanged.
REQ-031 Without LED_SCAN_DIM_EN, the DUTY port SHALL be absent and ON SHALL drive full duty.

Verification (GROUPS=4, WIDTH=8, DWELL=8, BLANK=2 unless stated)
REQ-032 Reset then EN=1 with DATA=32'h44332211:
- BLANK for 2 cycles;
- then LED_GND=4'b1110 and LED_A=8'h11 for 8 cycles;
- then 2 cycles blank;
- then LED_GND=4'b1101 and LED_A=8'h22.
REQ-033 With EN held high, FRAME_DONE SHALL pulse every 40 cycles, exactly one cycle wide, coincident with GROUP_IDX returning to 0.
REQ-034 DATA changed to 32'hFFFFFFFF during group 1 SHALL leave groups 2 and 3 showing 8'h33 and 8'h44; the next frame SHALL show 8'hFF for every group.
REQ-035 EN dropped in cycle 5 of group 2 ON:
- next cycle LED_GND=4'b1111, LED_A=0, GROUP_IDX=0;
- EN re-raised SHALL restart at group 0.
REQ-036 nRST pulsed low mid-ON, between clock edges, SHALL set LED_GND=4'b1111 within the same cycle; the assertion checker SHALL see no cycle with two LED_GND bits low.
REQ-037 With LED_SCAN_DIM_EN, DWELL=32 and DUTY=4: in each ON period, LED_GND SHALL be low for cycles 0-3 and 16-19 only.
